// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart transmitter among NREQ byte
// sources, round-robin with message lock, paced on uart_busy.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int BUSY_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*8-1:0] din,
  output logic [NREQ-1:0]   ack,
  input  logic              uart_busy,
  output logic              uart_wr,
  output logic [7:0]        uart_dat,
  output logic [1:0]        owner,
  output logic              active,
  output logic              err_to
);

  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    rr_ptr;
  logic [1:0]    g;
  logic [2:0]    scan_j;
  logic          scan_hit;
  logic          lock_hit;
  logic [CW-1:0] cnt;
  logic          start;
  logic          hi_to;

  // grant choice: lock holder keeps it, else first req from rr_ptr
  always_comb begin
    g        = rr_ptr;
    scan_j   = '0;
    scan_hit = 1'b0;
    lock_hit = lock[owner] & req[owner];
    for (int k = 0; k < NREQ; k++) begin
      scan_j = {1'b0, rr_ptr} + 3'(k);
      if (scan_j >= 3'(NREQ))
        scan_j = scan_j - 3'(NREQ);
      if (!scan_hit && req[scan_j[1:0]]) begin
        g        = scan_j[1:0];
        scan_hit = 1'b1;
      end
    end
    if (lock_hit)
      g = owner;
  end

  assign start = (state == IDLE) && (|req) && !uart_busy;

  // give up on busy when the count is about to reach its limit
  assign hi_to = (state == WAIT_HI) && !uart_busy &&
                 ((cnt + CW'(1)) >= CW'(BUSY_WAIT - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // next state plus strobe/ack decode
  always_comb begin
    state_nx = state;
    uart_wr  = 1'b0;
    ack      = '0;
    active   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = ISSUE;
      end
      ISSUE: begin
        uart_wr    = 1'b1;
        ack[owner] = 1'b1;
        state_nx   = WAIT_HI;
      end
      WAIT_HI: begin
        if (uart_busy)
          state_nx = WAIT_LO;
        else if (hi_to)
          state_nx = IDLE;
      end
      WAIT_LO: begin
        if (!uart_busy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // latch grant, byte and pointer on issue; busy wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      uart_dat <= '0;
      cnt      <= '0;
      err_to   <= 1'b0;
    end else begin
      if (start) begin
        owner    <= g;
        uart_dat <= din[{g, 3'b000} +: 8];
        rr_ptr   <= (g == 2'(NREQ - 1)) ? 2'd0 : g + 2'd1;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT_HI)
        cnt <= cnt + CW'(1);
      if (hi_to)
        err_to <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int HN   = 8192;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        uart_busy;
  logic        uart_wr;
  logic [7:0]  uart_dat;
  logic [1:0]  owner;
  logic        active;
  logic        err_to;

  uart_tx_arbiter #(.NREQ(NREQ), .BUSY_WAIT(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .din       (din),
    .ack       (ack),
    .uart_busy (uart_busy),
    .uart_wr   (uart_wr),
    .uart_dat  (uart_dat),
    .owner     (owner),
    .active    (active),
    .err_to    (err_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus state
  int          n = 0;
  bit          rnd = 0;
  bit          ext_busy = 0;
  int          ext_cnt = 0;
  int          rise_dly = 1;
  int          hold = 3;
  int          on_at = -1;
  int          off_at = -1;
  int          n_wr = 0;
  int          left [NREQ];
  logic [3:0]  req_v = '0;
  logic [3:0]  lock_v = '0;
  logic [3:0]  auto_clr = 4'hf;
  logic [31:0] din_v = '0;

  // history of what was driven at each negedge
  logic [3:0]  req_h  [HN];
  logic [3:0]  lock_h [HN];
  logic [31:0] din_h  [HN];
  bit          busy_h [HN];

  // reference model state
  int         last_s = -1;
  logic [1:0] owner_e = '0;
  int         rr_e = 0;
  logic [7:0] dat_e = '0;
  bit         err_e = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, want, n);
    end
  endtask

  // arbiter free at observation t: no strobe yet, timed out,
  // or busy rose in the window and has since fallen
  function automatic bit model_idle(int t);
    if (last_s < 0)
      return 1'b1;
    for (int k = 1; k < BW; k++) begin
      if (last_s + k > t - 1)
        return 1'b0;
      if (busy_h[last_s + k]) begin
        for (int m = last_s + k + 1; m <= t - 1; m++)
          if (!busy_h[m])
            return 1'b1;
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int pick(logic [3:0] r, logic [3:0] l);
    int i;
    if (l[owner_e] && r[owner_e])
      return int'(owner_e);
    for (int k = 0; k < NREQ; k++) begin
      i = (rr_e + k) % NREQ;
      if (r[i])
        return i;
    end
    return 0;
  endfunction

  task automatic drive();
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          left[i]--;
          if (left[i] <= 0) begin
            left[i]   = 0;
            req_v[i]  = 1'b0;
            lock_v[i] = 1'b0;
          end else begin
            din_v[i*8 +: 8] = 8'($urandom);
            lock_v[i] = (left[i] > 1) || ($urandom_range(0, 1) == 1);
          end
        end else if (req_v[i]) begin
          if ($urandom_range(0, 63) == 0) begin
            left[i]   = 0;
            req_v[i]  = 1'b0;
            lock_v[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          left[i]   = int'($urandom_range(1, 3));
          req_v[i]  = 1'b1;
          lock_v[i] = (left[i] > 1);
          din_v[i*8 +: 8] = 8'($urandom);
        end else begin
          lock_v[i] = ($urandom_range(0, 15) == 0);
        end
      end
      if (ext_cnt > 0)
        ext_cnt--;
      else if ($urandom_range(0, 31) == 0)
        ext_cnt = int'($urandom_range(1, 5));
      ext_busy = (ext_cnt > 0);
    end else begin
      req_v = req_v & ~(ack & auto_clr);
    end
    req       = req_v;
    lock      = lock_v;
    din       = din_v;
    uart_busy = ext_busy || (n >= on_at && n < off_at);
    req_h[n]  = req_v;
    lock_h[n] = lock_v;
    din_h[n]  = din_v;
    busy_h[n] = uart_busy;
  endtask

  task automatic step();
    int         g;
    bit         exp_wr;
    bit         quiet;
    logic [3:0] ack_e;
    @(negedge clk);
    n++;
    exp_wr = model_idle(n - 1) && (req_h[n-1] != 0) && !busy_h[n-1];
    ack_e  = '0;
    if (exp_wr) begin
      g        = pick(req_h[n-1], lock_h[n-1]);
      ack_e[g] = 1'b1;
      owner_e  = 2'(g);
      rr_e     = (g + 1) % NREQ;
      dat_e    = din_h[n-1][g*8 +: 8];
      last_s   = n;
    end
    if (last_s >= 0 && n == last_s + BW) begin
      quiet = 1;
      for (int k = 1; k < BW; k++)
        if (busy_h[last_s + k])
          quiet = 0;
      if (quiet)
        err_e = 1;
    end
    chk("wr", uart_wr, exp_wr);
    chk("ack", ack, ack_e);
    chk("dat", uart_dat, dat_e);
    chk("owner", owner, owner_e);
    chk("active", active, !model_idle(n));
    chk("err_to", err_to, err_e);
    if (uart_wr) begin
      n_wr++;
      if (rnd) begin
        rise_dly = ($urandom_range(0, 9) == 0) ? 0
                 : int'($urandom_range(1, BW + 1));
        hold = int'($urandom_range(1, 6));
      end
      if (rise_dly > 0) begin
        on_at  = n + rise_dly;
        off_at = on_at + hold;
      end else begin
        on_at  = -1;
        off_at = -1;
      end
    end
    drive();
  endtask

  task automatic wait_strobe(output int s);
    s = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (uart_wr) begin
        s = n;
        break;
      end
    end
    if (s < 0)
      chk("strobe_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_wr", uart_wr, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dat", uart_dat, 0);
    chk("rst_owner", owner, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err_to, 0);
    req_v    = '0;
    lock_v   = '0;
    ext_busy = 0;
    ext_cnt  = 0;
    on_at    = -1;
    off_at   = -1;
    for (int i = 0; i < NREQ; i++)
      left[i] = 0;
    repeat (2) @(negedge clk);
    n += 2;
    rst     = 1'b0;
    last_s  = -1;
    owner_e = '0;
    rr_e    = 0;
    dat_e   = '0;
    err_e   = 0;
    drive();
  endtask

  initial begin
    int s;
    int w0;
    int fall_n;
    int exp_fall;
    int k;
    int ne;
    rst       = 1'b0;
    req       = '0;
    lock      = '0;
    din       = '0;
    uart_busy = 1'b0;
    for (int i = 0; i < NREQ; i++)
      left[i] = 0;
    do_reset();

    // single byte
    rise_dly = 2;
    hold     = 20;
    req_v    = 4'b0001;
    din_v    = 32'h0000_0041;
    w0       = n_wr;
    wait_strobe(s);
    chk("t1_dat", uart_dat, 8'h41);
    chk("t1_ack", ack, 4'b0001);
    exp_fall = s + 2 + 20 + 1;
    fall_n   = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!active) begin
        fall_n = n;
        break;
      end
    end
    chk("t1_fall", fall_n, exp_fall);
    repeat (10) step();
    chk("t1_nwr", n_wr - w0, 1);

    // round robin
    do_reset();
    rise_dly = 1;
    hold     = 3;
    req_v    = 4'b1111;
    din_v    = 32'hA3A2_A1A0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(s);
      chk("t2_owner", owner, i);
      chk("t2_dat", uart_dat, 8'hA0 + i);
    end

    // locked message from requester 2
    do_reset();
    auto_clr = 4'b0001;
    req_v    = 4'b0100;
    lock_v   = 4'b0100;
    din_v    = 32'h0010_0000;
    wait_strobe(s);
    chk("t3_b0", uart_dat, 8'h10);
    req_v[0]      = 1'b1;
    din_v[7:0]    = 8'h55;
    din_v[23:16]  = 8'h11;
    wait_strobe(s);
    chk("t3_b1", uart_dat, 8'h11);
    din_v[23:16]  = 8'h12;
    wait_strobe(s);
    chk("t3_b2", uart_dat, 8'h12);
    req_v[2]  = 1'b0;
    lock_v[2] = 1'b0;
    wait_strobe(s);
    chk("t3_b3", uart_dat, 8'h55);
    chk("t3_own", owner, 0);
    auto_clr = 4'hf;

    // busy held at arbitration
    repeat (30) step();
    ext_busy   = 1;
    req_v      = 4'b0001;
    din_v[7:0] = 8'h77;
    w0 = n_wr;
    repeat (10) step();
    chk("t5_held", n_wr - w0, 0);
    ext_busy = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      k++;
      if (uart_wr)
        break;
    end
    chk("t5_lat_ok", (k <= 2), 1);
    chk("t5_dat", uart_dat, 8'h77);

    // busy never rises
    repeat (30) step();
    rise_dly    = 0;
    req_v       = 4'b0010;
    din_v[15:8] = 8'h99;
    wait_strobe(s);
    ne = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (err_to) begin
        ne = n;
        break;
      end
    end
    chk("t4_err_dly", ne - s, BW);
    chk("t4_idle", active, 0);
    rise_dly   = 2;
    hold       = 3;
    req_v      = 4'b0001;
    din_v[7:0] = 8'h5A;
    wait_strobe(s);
    chk("t4_next", uart_dat, 8'h5A);
    chk("t4_sticky", err_to, 1);

    // async reset while the byte is shifting
    repeat (10) step();
    rise_dly     = 1;
    hold         = 20;
    req_v        = 4'b0100;
    din_v[23:16] = 8'hC6;
    wait_strobe(s);
    repeat (4) step();
    chk("t6_pre", active, 1);
    do_reset();
    rise_dly     = 2;
    hold         = 3;
    req_v        = 4'b1010;
    din_v[15:8]  = 8'hB1;
    din_v[31:24] = 8'hB3;
    wait_strobe(s);
    chk("t6_owner", owner, 1);
    chk("t6_dat", uart_dat, 8'hB1);

    // random traffic
    do_reset();
    rnd = 1;
    repeat (3000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
